// File: rtl/echo_height_meter.sv
// Ultrasonic echo timer: fires a trigger, measures the returned echo width and
// publishes subject height = mount height - distance with a one-cycle save strobe.
//
// Latency: with start sampled at edge 0, trig is high for TRIG_CYCLES cycles.
// WAIT_ECHO is entered at cycle 1+TRIG_CYCLES. Let W be the number of WAIT_ECHO
// cycles before echo_s rises, and N the number of cycles echo_s stays high.
// save_height is then high in cycle 1 + TRIG_CYCLES + W + N + 2.
// The 2-flop echo synchroniser adds 2 of the W cycles. When counted from the
// raw echo edge, the delay is 1 + TRIG_CYCLES + W_raw + N + 2 + 2.
module echo_height_meter #(
  parameter int TRIG_CYCLES      = 120,
  parameter int CYCLES_PER_CM    = 696,
  parameter int TIMEOUT_CYCLES   = 360000,
  parameter int HOLDOFF_CYCLES   = 720000,
  parameter int SENSOR_HEIGHT_CM = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       echo,
  output logic       trig,
  output logic [7:0] new_height,
  output logic       save_height,
  output logic       busy,
  output logic       timeout_err
);

  localparam int TW = $clog2(TRIG_CYCLES + 1);
  localparam int SW = $clog2(CYCLES_PER_CM + 1);
  localparam int OW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

  localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_CYCLES - 1);
  localparam logic [SW-1:0] SUB_LAST  = SW'(CYCLES_PER_CM - 1);
  localparam logic [OW-1:0] TO_LAST   = OW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);
  localparam logic [7:0]    SENSOR_H  = 8'(SENSOR_HEIGHT_CM);

  typedef enum logic [2:0] {
    IDLE, TRIG, WAIT_ECHO, MEASURE, CALC, HOLDOFF
  } state_t;

  state_t          state, state_next;
  logic            echo_q1, echo_s;
  logic [TW-1:0]   trig_cnt;
  logic [SW-1:0]   sub_cnt;
  logic [OW-1:0]   to_cnt;
  logic [HW-1:0]   hold_cnt;
  logic [7:0]      dist_cm;
  logic            timing;
  logic            timeout_hit;
  logic            hold_done;

  assign timing      = (state == WAIT_ECHO) || (state == MEASURE);
  assign timeout_hit = timing && (to_cnt == TO_LAST);
  assign hold_done   = (hold_cnt == HOLD_LAST);

  assign trig = (state == TRIG);
  assign busy = (state != IDLE);

  // Timeout is tested before the echo fall so it wins when both occur together.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:      if (start) state_next = TRIG;
      TRIG:      if (trig_cnt == TRIG_LAST) state_next = WAIT_ECHO;
      WAIT_ECHO: if (timeout_hit) state_next = HOLDOFF;
                 else if (echo_s) state_next = MEASURE;
      MEASURE:   if (timeout_hit) state_next = HOLDOFF;
                 else if (!echo_s) state_next = CALC;
      CALC:      state_next = HOLDOFF;
      HOLDOFF:   if (hold_done && !echo_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      echo_q1     <= 1'b0;
      echo_s      <= 1'b0;
      trig_cnt    <= '0;
      sub_cnt     <= '0;
      to_cnt      <= '0;
      hold_cnt    <= '0;
      dist_cm     <= '0;
      new_height  <= '0;
      save_height <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      state       <= state_next;
      echo_q1     <= echo;
      echo_s      <= echo_q1;
      save_height <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          trig_cnt <= '0;
          hold_cnt <= '0;
        end
        TRIG: begin
          trig_cnt <= trig_cnt + 1'b1;
          to_cnt   <= '0;
          sub_cnt  <= '0;
          dist_cm  <= '0;
        end
        WAIT_ECHO, MEASURE: begin
          to_cnt <= to_cnt + 1'b1;
          // The rising-edge cycle seen in WAIT_ECHO is the first echo cycle counted.
          if (echo_s) begin
            if (sub_cnt == SUB_LAST) begin
              sub_cnt <= '0;
              if (dist_cm != 8'hFF) dist_cm <= dist_cm + 1'b1;
            end else begin
              sub_cnt <= sub_cnt + 1'b1;
            end
          end
          if (timeout_hit) timeout_err <= 1'b1;
        end
        CALC: begin
          if (dist_cm <= SENSOR_H) new_height <= SENSOR_H - dist_cm;
          else                     new_height <= '0;
          save_height <= 1'b1;
        end
        HOLDOFF: begin
          if (!hold_done) hold_cnt <= hold_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_echo_height_meter.sv
// Directed bench for echo_height_meter with short timing parameters so that
// every scenario runs in a few thousand cycles.
module tb_echo_height_meter;

  logic       clk;
  logic       reset;
  logic       start;
  logic       echo;
  logic       trig;
  logic [7:0] new_height;
  logic       save_height;
  logic       busy;
  logic       timeout_err;

  echo_height_meter #(
    .TRIG_CYCLES     (4),
    .CYCLES_PER_CM   (10),
    .TIMEOUT_CYCLES  (3000),
    .HOLDOFF_CYCLES  (20),
    .SENSOR_HEIGHT_CM(200)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .echo       (echo),
    .trig       (trig),
    .new_height (new_height),
    .save_height(save_height),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state, updated only from tick() at the falling edge.
  int cyc = 0;
  int n_save, n_to, n_trig, n_both, n_busy;
  int save_cyc, to_cyc, trig_fall_cyc, busy_fall_cyc, echo_fall_cyc;
  logic prev_trig = 1'b0;
  logic prev_busy = 1'b0;

  task automatic clear_mon();
    n_save = 0; n_to = 0; n_trig = 0; n_both = 0; n_busy = 0;
    save_cyc = -1; to_cyc = -1; trig_fall_cyc = -1; busy_fall_cyc = -1;
    echo_fall_cyc = -1;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (save_height) begin n_save++; save_cyc = cyc; end
    if (timeout_err) begin n_to++; to_cyc = cyc; end
    if (save_height && timeout_err) n_both++;
    if (trig) n_trig++;
    if (busy) n_busy++;
    if (prev_trig && !trig) trig_fall_cyc = cyc;
    if (prev_busy && !busy) busy_fall_cyc = cyc;
    prev_trig = trig;
    prev_busy = busy;
  endtask

  task automatic fire_start();
    int k;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (trig && k < 100) begin tick(); k++; end
    n_checks++;
    if (trig !== 1'b0) begin
      n_fail++;
      $display("FAIL trig_fall: trig=%0b still high after %0d cycles, required 0", trig, k);
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    while (busy && k < budget) begin tick(); k++; end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: busy=%0b after %0d cycles, required 0", tag, busy, budget);
    end
  endtask

  // One full measurement: trigger, wait `gap` cycles, echo high for `high` cycles.
  task automatic do_measure(input int gap, input int high);
    clear_mon();
    fire_start();
    repeat (gap) tick();
    echo = 1'b1;
    repeat (high) tick();
    echo = 1'b0;
    echo_fall_cyc = cyc;
    wait_idle(500, "measure");
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    clear_mon();
    repeat (50) tick();
    n_checks++;
    if (n_trig !== 0 || n_save !== 0 || n_to !== 0 || n_busy !== 0) begin
      n_fail++;
      $display("FAIL reset_idle: trig=%0d save=%0d to=%0d busy=%0d cycles high, required all 0",
               n_trig, n_save, n_to, n_busy);
    end
    n_checks++;
    if (new_height !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_height: new_height=%0d, required 0", new_height);
    end
  endtask

  task automatic test_basic();
    do_measure(30, 500);
    n_checks++;
    if (n_trig !== 4) begin
      n_fail++;
      $display("FAIL basic_trig_width: trig high %0d cycles, required 4", n_trig);
    end
    n_checks++;
    if (n_save !== 1 || n_to !== 0) begin
      n_fail++;
      $display("FAIL basic_strobes: save=%0d timeout=%0d, required 1 and 0", n_save, n_to);
    end
    n_checks++;
    if (new_height !== 8'd150) begin
      n_fail++;
      $display("FAIL basic_height: new_height=%0d, required 150", new_height);
    end
    n_checks++;
    if (save_cyc - echo_fall_cyc !== 4) begin
      n_fail++;
      $display("FAIL basic_latency: save %0d cycles after echo fall, required 4",
               save_cyc - echo_fall_cyc);
    end
    n_checks++;
    if (save_cyc - trig_fall_cyc !== 534) begin
      n_fail++;
      $display("FAIL basic_total: save %0d cycles after WAIT_ECHO entry, required 534",
               save_cyc - trig_fall_cyc);
    end
    n_checks++;
    if (busy_fall_cyc - save_cyc < 20) begin
      n_fail++;
      $display("FAIL basic_holdoff: idle %0d cycles after save, required >= 20",
               busy_fall_cyc - save_cyc);
    end
  endtask

  task automatic test_timeout();
    clear_mon();
    fire_start();
    wait_idle(4000, "timeout");
    n_checks++;
    if (n_to !== 1 || n_save !== 0) begin
      n_fail++;
      $display("FAIL timeout_strobes: timeout=%0d save=%0d, required 1 and 0", n_to, n_save);
    end
    n_checks++;
    if (to_cyc - trig_fall_cyc !== 3000) begin
      n_fail++;
      $display("FAIL timeout_time: timeout_err %0d cycles after WAIT_ECHO entry, required 3000",
               to_cyc - trig_fall_cyc);
    end
    n_checks++;
    if (new_height !== 8'd150) begin
      n_fail++;
      $display("FAIL timeout_height: new_height=%0d, required 150 (held)", new_height);
    end
  endtask

  task automatic test_boundaries();
    do_measure(10, 2100);
    n_checks++;
    if (n_save !== 1 || new_height !== 8'd0) begin
      n_fail++;
      $display("FAIL clamp_height: save=%0d new_height=%0d, required 1 and 0", n_save, new_height);
    end
    do_measure(10, 9);
    n_checks++;
    if (n_save !== 1 || new_height !== 8'd200) begin
      n_fail++;
      $display("FAIL zero_dist_height: save=%0d new_height=%0d, required 1 and 200",
               n_save, new_height);
    end
  endtask

  task automatic test_ignore_start_and_stuck_echo();
    int k;
    clear_mon();
    fire_start();
    repeat (10) tick();
    echo = 1'b1;
    for (int i = 0; i < 500; i++) begin
      tick();
      start = (i % 50 == 7);
    end
    start = 1'b0;
    echo  = 1'b0;
    k = 0;
    while (n_save == 0 && k < 100) begin tick(); k++; end
    echo = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      start = (i % 10 == 3);
    end
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stuck_echo_busy: busy=%0b with echo held high, required 1", busy);
    end
    echo = 1'b0;
    wait_idle(20, "stuck");
    repeat (20) tick();
    n_checks++;
    if (n_trig !== 4 || n_save !== 1 || n_to !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_start: trig=%0d save=%0d to=%0d busy=%0b, required 4 1 0 0",
               n_trig, n_save, n_to, busy);
    end
    n_checks++;
    if (new_height !== 8'd150) begin
      n_fail++;
      $display("FAIL ignore_height: new_height=%0d, required 150", new_height);
    end
  endtask

  task automatic test_reset_mid_measure();
    clear_mon();
    fire_start();
    repeat (5) tick();
    echo = 1'b1;
    repeat (200) tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if (trig !== 1'b0 || busy !== 1'b0 || new_height !== 8'd0 ||
        save_height !== 1'b0 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: trig=%0b busy=%0b height=%0d save=%0b to=%0b, required all 0",
               trig, busy, new_height, save_height, timeout_err);
    end
    reset = 1'b0;
    echo  = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (n_save !== 0 || n_to !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_strobes: save=%0d to=%0d busy=%0b, required 0 0 0",
               n_save, n_to, busy);
    end
    do_measure(30, 500);
    n_checks++;
    if (n_save !== 1 || new_height !== 8'd150) begin
      n_fail++;
      $display("FAIL midreset_remeasure: save=%0d new_height=%0d, required 1 and 150",
               n_save, new_height);
    end
  endtask

  int total_both = 0;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    echo  = 1'b0;
    test_reset();
    test_basic();
    total_both += n_both;
    test_timeout();
    total_both += n_both;
    test_boundaries();
    total_both += n_both;
    test_ignore_start_and_stuck_echo();
    total_both += n_both;
    test_reset_mid_measure();
    total_both += n_both;
    n_checks++;
    if (total_both !== 0) begin
      n_fail++;
      $display("FAIL strobe_exclusive: save and timeout together %0d times, required 0", total_both);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/echo_height_meter.md
Name: echo_height_meter

Overview:
Upstream measurement stage for the height history buffer. On request, it fires an ultrasonic sensor trigger and times the returned echo pulse. It converts the echo width to distance in cm, then to subject height as mount height minus distance. It emits the 8-bit result with a one-cycle save strobe, wired directly to the history block's new_height / save_height inputs.

Parameters:
TRIG_CYCLES, 120, trigger pulse width in clk cycles (10 us at 12 MHz)
CYCLES_PER_CM, 696, clk cycles of echo per cm of distance (58 us/cm at 12 MHz)
TIMEOUT_CYCLES, 360000, max cycles from WAIT_ECHO entry to echo fall before abort (30 ms)
HOLDOFF_CYCLES, 720000, minimum idle gap after any measurement before next start accepted (60 ms)
SENSOR_HEIGHT_CM, 200, sensor mount height above floor in cm (must be <= 255)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  measurement request; sampled only in IDLE
echo  input  1  raw sensor echo, asynchronous; 2-flop synchronised internally to echo_s
trig  output  1  sensor trigger pulse
new_height  output  8  last valid height in cm; registered, held between results
save_height  output  1  one-cycle strobe, high in the cycle new_height takes a new value
busy  output  1  high in every state except IDLE
timeout_err  output  1  one-cycle strobe on measurement abort

Behaviour:
- Reset (synchronous, active-high): state=IDLE; trig=0, new_height=0, save_height=0, busy=0, timeout_err=0; all counters and sync flops cleared. Reset mid-measurement aborts immediately, with no strobe.
- echo_s is echo delayed 2 clk. All timing uses echo_s only.
- FSM states: IDLE, TRIG, WAIT_ECHO, MEASURE, CALC, HOLDOFF.
- IDLE: start=1 -> TRIG on the next cycle. start in any other state is ignored and is not queued.
- TRIG: trig=1 for exactly TRIG_CYCLES cycles, then -> WAIT_ECHO with trig=0.
- WAIT_ECHO: timeout counter starts at 0 on entry and increments every cycle in WAIT_ECHO and MEASURE. echo_s=1 -> MEASURE.
- MEASURE: each cycle with echo_s=1 advances a sub-counter 0..CYCLES_PER_CM-1. On wrap, dist_cm increments, saturating at 255. So dist_cm = floor(N/CYCLES_PER_CM), where N = cycles echo_s high. echo_s=0 -> CALC.
- Timeout: if the timeout counter reaches TIMEOUT_CYCLES in WAIT_ECHO or MEASURE before echo_s falls:
  - timeout_err=1 for one cycle;
  - -> HOLDOFF;
  - new_height unchanged, no save_height.
  - If echo falls in the same cycle the counter reaches the limit, the timeout takes priority.
- CALC (1 cycle): new_height <= SENSOR_HEIGHT_CM - dist_cm if dist_cm <= SENSOR_HEIGHT_CM, else 0 (no underflow wrap). save_height=1 in the cycle after CALC, coincident with the updated new_height. -> HOLDOFF.
- HOLDOFF: counts HOLDOFF_CYCLES. Exits to IDLE only when the count is done AND echo_s=0; a stuck-high echo keeps the block in HOLDOFF.
- Latency, start to save_height: 1 + TRIG_CYCLES + (WAIT_ECHO cycles) + N + 2 sync + 2 cycles; exact count to be documented in the RTL header.
- save_height and timeout_err are never high in the same cycle. Each fires at most once per measurement.

Test Plan:
Bench parameters for all scenarios: TRIG_CYCLES=4, CYCLES_PER_CM=10, TIMEOUT_CYCLES=3000, HOLDOFF_CYCLES=20, SENSOR_HEIGHT_CM=200.
- Reset then idle 50 cycles -> trig, save_height, timeout_err, busy stay 0; new_height=0.
- start pulse; echo rises 30 cycles after trig falls, high 500 cycles -> trig high exactly 4 cycles; one save_height strobe; new_height=150; busy returns 0 >=20 cycles later.
- Echo high 2100 cycles -> dist 210 > 200 -> new_height=0 with save_height strobe (no wrap to 246). Echo high 9 cycles -> dist 0 -> new_height=200.
- No echo after trigger -> timeout_err single strobe exactly 3000 cycles after WAIT_ECHO entry; no save_height; new_height keeps prior value (150).
- start asserted repeatedly during MEASURE and HOLDOFF -> ignored; exactly one measurement. Echo held high through HOLDOFF -> FSM stays busy until echo drops.
- reset asserted mid-MEASURE -> next cycle trig=0, busy=0, new_height=0, no strobes. A subsequent 500-cycle echo measurement yields 150.
